dtpu_infifo_responder: RTL and testbench



---
 rtl/dtpu_stream_pkg.sv | 21 ++
 rtl/dtpu_fifo_mem.sv | 25 ++
 rtl/dtpu_infifo_responder.sv | 127 ++++++++++++
 tb/tb_dtpu_infifo_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dtpu_stream_pkg.sv
// Shared constants and sizing helpers for the DTPU input-stream FIFO.
package dtpu_stream_pkg;

  localparam int DATA_WIDTH_FIFO_IN_DEF = 64;
  localparam int ENTRY_WIDTH            = DATA_WIDTH_FIFO_IN_DEF + 1;
  localparam int LAST_BIT               = DATA_WIDTH_FIFO_IN_DEF;

  // Pointer carries one extra wrap bit above the index bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int last_bit_idx(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/dtpu_fifo_mem.sv
// Simple dual-port store: synchronous write, asynchronous read, array not reset.
module dtpu_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/dtpu_infifo_responder.sv
// AXI4-Stream to first-word-fall-through FIFO responder with occupancy and frame tracking.
// Optional underflow error flag enabled by defining DTPU_INFIFO_ERR_EN.
module dtpu_infifo_responder
  import dtpu_stream_pkg::*;
#(
  parameter int DATA_WIDTH_FIFO_IN = 64,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_TH     = 14
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH_FIFO_IN-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH_FIFO_IN-1:0] infifo_dout,
  output logic                          infifo_last,
  input  logic                          infifo_read,
  output logic                          infifo_is_empty,
  output logic [ptr_width(DEPTH)-1:0]   level,
  output logic                          almost_full,
`ifdef DTPU_INFIFO_ERR_EN
  output logic                          err_underflow,
  input  logic                          err_clear,
`endif
  output logic [ptr_width(DEPTH)-1:0]   frames_pending
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam int EW = entry_width(DATA_WIDTH_FIFO_IN);
  localparam int LB = last_bit_idx(DATA_WIDTH_FIFO_IN);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] AF_TH   = PW'(ALMOST_FULL_TH);

  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [PW-1:0] level_r, level_nxt_s;
  logic [PW-1:0] frames_r, frames_nxt_s;
  logic          almost_full_r;
  logic          empty_s, full_s, push_s, pop_s;
  logic [EW-1:0] hold_r, rd_entry_s, head_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);

  assign s_axis_tready = !full_s && !reset;
  assign push_s        = s_axis_tvalid && s_axis_tready;
  assign pop_s         = infifo_read && !empty_s;

  dtpu_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rd_entry_s)
  );

  // The array is never reset, so an empty store shows the last popped entry (0 after reset).
  assign head_s          = empty_s ? hold_r : rd_entry_s;
  assign infifo_dout     = head_s[DATA_WIDTH_FIFO_IN-1:0];
  assign infifo_last     = head_s[LB];
  assign infifo_is_empty = empty_s;
  assign level           = level_r;
  assign frames_pending  = frames_r;
  assign almost_full     = almost_full_r;

  // Next occupancy and frame count
  always_comb begin
    level_nxt_s  = level_r;
    frames_nxt_s = frames_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + PTR_ONE;
      2'b01:   level_nxt_s = level_r - PTR_ONE;
      default: level_nxt_s = level_r;
    endcase
    case ({push_s && s_axis_tlast, pop_s && rd_entry_s[LB]})
      2'b10:   frames_nxt_s = frames_r + PTR_ONE;
      2'b01:   frames_nxt_s = frames_r - PTR_ONE;
      default: frames_nxt_s = frames_r;
    endcase
  end

  // Pointers, counters, head hold register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      level_r       <= {PW{1'b0}};
      frames_r      <= {PW{1'b0}};
      almost_full_r <= 1'b0;
      hold_r        <= {EW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        hold_r   <= rd_entry_s;
      end
      level_r       <= level_nxt_s;
      frames_r      <= frames_nxt_s;
      almost_full_r <= (level_nxt_s >= AF_TH);
    end
  end

`ifdef DTPU_INFIFO_ERR_EN
  logic err_underflow_r;

  // Sticky underflow flag; a new underflow beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_underflow_r <= 1'b0;
    end else if (infifo_read && empty_s) begin
      err_underflow_r <= 1'b1;
    end else if (err_clear) begin
      err_underflow_r <= 1'b0;
    end
  end

  assign err_underflow = err_underflow_r;
`endif

endmodule

// File: tb/tb_dtpu_infifo_responder.sv
// Self-checking bench for dtpu_infifo_responder against a queue-based reference model.
module tb_dtpu_infifo_responder;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int AF_TH = 14;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] infifo_dout;
  logic          infifo_last;
  logic          infifo_read = 1'b0;
  logic          infifo_is_empty;
  logic [PW-1:0] level;
  logic          almost_full;
  logic [PW-1:0] frames_pending;
  logic          err_clear = 1'b0;
`ifdef DTPU_INFIFO_ERR_EN
  logic          err_underflow;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: queue of {last, data}, last popped entry, sticky error
  logic [DW:0] mq[$];
  logic [DW:0] hold_m = '0;
  logic        err_m = 1'b0;

  always #5 clk = ~clk;

  dtpu_infifo_responder #(
    .DATA_WIDTH_FIFO_IN (DW),
    .DEPTH              (DEPTH),
    .ALMOST_FULL_TH     (AF_TH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .infifo_dout     (infifo_dout),
    .infifo_last     (infifo_last),
    .infifo_read     (infifo_read),
    .infifo_is_empty (infifo_is_empty),
    .level           (level),
    .almost_full     (almost_full),
`ifdef DTPU_INFIFO_ERR_EN
    .err_underflow   (err_underflow),
    .err_clear       (err_clear),
`endif
    .frames_pending  (frames_pending)
  );

  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int frames_m();
    int n = 0;
    foreach (mq[i]) if (mq[i][DW]) n++;
    return n;
  endfunction

  task automatic check_state();
    logic [DW:0] head;
    head = (mq.size() == 0) ? hold_m : mq[0];
    chk("empty",       infifo_is_empty, mq.size() == 0);
    chk("level",       level, mq.size());
    chk("frames",      frames_pending, frames_m());
    chk("almost_full", almost_full, mq.size() >= AF_TH);
    chk("dout",        infifo_dout, head[DW-1:0]);
    chk("last",        infifo_last, head[DW]);
`ifdef DTPU_INFIFO_ERR_EN
    chk("err_underflow", err_underflow, err_m);
`endif
  endtask

  // One clock: drive inputs, check tready before the edge, update model, check after the edge
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic rd);
    logic acc, popv;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    infifo_read   = rd;
    #1;
    chk("tready", s_axis_tready, mq.size() < DEPTH);
    @(posedge clk);
    acc  = v && (mq.size() < DEPTH);
    popv = rd && (mq.size() > 0);
    if (rd && mq.size() == 0) err_m = 1'b1;
    else if (err_clear)       err_m = 1'b0;
    if (popv) hold_m = mq.pop_front();
    if (acc) mq.push_back({l, d});
    #1;
    check_state();
  endtask

  task automatic drain();
    while (mq.size() > 0) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", s_axis_tready, 1'b0);
    check_state();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_tready", s_axis_tready, 1'b1);
    check_state();

    // Three words, frame end on the third
    step(1'b1, 64'h11, 1'b0, 1'b0);
    step(1'b1, 64'h22, 1'b0, 1'b0);
    step(1'b1, 64'h33, 1'b1, 1'b0);
    chk("three_level", level, 3);
    chk("three_frames", frames_pending, 1);
    chk("three_dout", infifo_dout, 64'h11);
    drain();
    chk("hold_after_drain", infifo_dout, 64'h33);

    // Fill to full, hold a 17th beat, then pop one while it is offered
    for (int i = 0; i < DEPTH; i++) step(1'b1, 64'(i), (i % 4) == 3, 1'b0);
    chk("full_level", level, DEPTH);
    step(1'b1, 64'd16, 1'b0, 1'b0);
    step(1'b1, 64'd16, 1'b0, 1'b0);
    chk("blocked_level", level, DEPTH);
    step(1'b1, 64'd16, 1'b1, 1'b1);
    chk("pop_from_full_level", level, DEPTH - 1);
    chk("pop_from_full_head", infifo_dout, 64'd1);
    step(1'b1, 64'd16, 1'b1, 1'b0);
    chk("refill_level", level, DEPTH);
    drain();

    // Underflow read
    step(1'b0, '0, 1'b0, 1'b1);
    chk("underflow_level", level, 0);
    step(1'b0, '0, 1'b0, 1'b0);
`ifdef DTPU_INFIFO_ERR_EN
    chk("err_sticky", err_underflow, 1'b1);
    err_clear = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    chk("err_cleared", err_underflow, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("err_set_wins", err_underflow, 1'b1);
    err_clear = 1'b0;
`endif

    // Steady streaming: prefill 5, then push and pop every cycle across several wraps
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
      chk("stream_level", level, 5);
    end

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 2) != 0));
    drain();

    // Asynchronous reset with level 5, two frames pending
    for (int i = 0; i < 5; i++) step(1'b1, 64'(100 + i), (i == 1) || (i == 4), 1'b0);
    chk("pre_reset_frames", frames_pending, 2);
    s_axis_tvalid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    hold_m = '0;
    err_m  = 1'b0;
    chk("async_rst_tready", s_axis_tready, 1'b0);
    check_state();
    @(posedge clk);
    #1;
    chk("rst_hold_tready", s_axis_tready, 1'b0);
    check_state();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 64'hABCD, 1'b1, 1'b0);
    chk("after_rst_push", infifo_dout, 64'hABCD);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
